// File: rtl/acc_pair_drain.sv
// Snapshots NUM_ACC low/high accumulator pairs on capture and drains them
// as a valid/ready word stream: lane0 lo, lane0 hi, lane1 lo, ... laneN-1 hi.

module acc_pair_lane #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] lo_in,
  input  logic [DATA_WIDTH-1:0] hi_in,
  output logic [DATA_WIDTH-1:0] lo_q,
  output logic [DATA_WIDTH-1:0] hi_q
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (load) begin
      lo_q <= lo_in;
      hi_q <= hi_in;
    end
  end
endmodule

module acc_pair_drain #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_ACC    = 4,
  localparam int LW        = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          capture,
  input  logic [NUM_ACC*DATA_WIDTH-1:0] acc_low,
  input  logic [NUM_ACC*DATA_WIDTH-1:0] acc_hi,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_is_hi,
  output logic [LW-1:0]                 out_lane,
  output logic                          out_last,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          clr_overrun
);
  localparam int KW = $clog2(2*NUM_ACC);
  localparam logic [KW-1:0] K_LAST = KW'(2*NUM_ACC-1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_nxt;
  logic [KW-1:0] k;
  logic [NUM_ACC-1:0][DATA_WIDTH-1:0] sh_lo, sh_hi;
  logic accept, last_acc, load, drop;
  logic [LW-1:0] lane;

  assign accept   = (state == SEND) && out_ready;
  assign last_acc = accept && (k == K_LAST);
  // A capture is taken only when the previous snapshot is fully handed off.
  assign load     = capture && ((state == IDLE) || last_acc);
  assign drop     = capture && (state == SEND) && !last_acc;
  assign lane     = LW'(k >> 1);

  for (genvar g = 0; g < NUM_ACC; g++) begin : g_lane
    acc_pair_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load),
      .lo_in   (acc_low[g*DATA_WIDTH +: DATA_WIDTH]),
      .hi_in   (acc_hi[g*DATA_WIDTH +: DATA_WIDTH]),
      .lo_q    (sh_lo[g]),
      .hi_q    (sh_hi[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (capture) state_nxt = SEND;
      SEND: if (last_acc && !capture) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == SEND);
    busy      = (state == SEND);
    out_last  = (state == SEND) && (k == K_LAST);
    out_is_hi = k[0];
    out_lane  = lane;
    out_data  = k[0] ? sh_hi[lane] : sh_lo[lane];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k       <= '0;
      overrun <= 1'b0;
    end else begin
      if (load)                k <= '0;
      else if (accept && !last_acc) k <= k + KW'(1);
      // A dropped capture in the same cycle as a clear still leaves the flag set.
      if (drop)             overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_acc_pair_drain.sv
// Randomized bench for acc_pair_drain against a word-queue reference model,
// plus a directed NUM_ACC=1 instance for the single-lane boundary.

module tb_acc_pair_drain;
  localparam int DW = 18;
  localparam int NA = 4;

  typedef struct {
    logic [DW-1:0] data;
    int            lane;
    bit            hi;
  } word_t;

  logic clk = 0;
  always #5 clk = ~clk;

  logic reset_n, capture, out_ready, clr_overrun;
  logic [DW-1:0] lo [NA];
  logic [DW-1:0] hi [NA];
  logic [NA*DW-1:0] acc_low, acc_hi;
  logic [DW-1:0] out_data;
  logic out_valid, out_is_hi, out_last, busy, overrun;
  logic [1:0] out_lane;

  always_comb begin
    acc_low = '0;
    acc_hi  = '0;
    for (int i = 0; i < NA; i++) begin
      acc_low[i*DW +: DW] = lo[i];
      acc_hi[i*DW +: DW]  = hi[i];
    end
  end

  acc_pair_drain #(.DATA_WIDTH(DW), .NUM_ACC(NA)) dut (
    .clk(clk), .reset_n(reset_n), .capture(capture),
    .acc_low(acc_low), .acc_hi(acc_hi),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_is_hi(out_is_hi), .out_lane(out_lane), .out_last(out_last),
    .busy(busy), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  logic capture1, out_ready1, clr_overrun1;
  logic [DW-1:0] acc_low1, acc_hi1, out_data1;
  logic out_valid1, out_is_hi1, out_last1, busy1, overrun1;
  logic [0:0] out_lane1;

  acc_pair_drain #(.DATA_WIDTH(DW), .NUM_ACC(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .capture(capture1),
    .acc_low(acc_low1), .acc_hi(acc_hi1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_is_hi(out_is_hi1), .out_lane(out_lane1), .out_last(out_last1),
    .busy(busy1), .overrun(overrun1), .clr_overrun(clr_overrun1)
  );

  int checks = 0;
  int errors = 0;
  word_t q[$];
  bit m_ovr;
  bit scramble;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("valid", out_valid, q.size() > 0);
    chk("busy", busy, q.size() > 0);
    chk("overrun", overrun, m_ovr);
    if (q.size() > 0) begin
      chk("data", out_data, q[0].data);
      chk("lane", out_lane, q[0].lane);
      chk("is_hi", out_is_hi, q[0].hi);
      chk("last", out_last, q.size() == 1);
    end
  endtask

  // Called just after a negedge: drives one cycle, predicts, checks at next negedge.
  task automatic step(input bit cap, input bit rdy, input bit clr);
    bit accept, last_acc, drop;
    word_t w;
    accept   = (q.size() > 0) && rdy;
    last_acc = accept && (q.size() == 1);
    drop     = cap && (q.size() > 0) && !last_acc;
    if (accept) void'(q.pop_front());
    if (cap && !drop)
      for (int i = 0; i < NA; i++) begin
        w.lane = i; w.hi = 0; w.data = lo[i]; q.push_back(w);
        w.hi = 1; w.data = hi[i]; q.push_back(w);
      end
    if (drop) m_ovr = 1;
    else if (clr) m_ovr = 0;
    capture = cap; out_ready = rdy; clr_overrun = clr;
    @(posedge clk);
    #1;
    if (scramble)
      for (int i = 0; i < NA; i++) begin
        lo[i] = DW'($urandom); hi[i] = DW'($urandom);
      end
    capture = 0; clr_overrun = 0;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    reset_n = 0; capture = 0; out_ready = 0; clr_overrun = 0;
    capture1 = 0; out_ready1 = 0; clr_overrun1 = 0; acc_low1 = '0; acc_hi1 = '0;
    for (int i = 0; i < NA; i++) begin lo[i] = '0; hi[i] = '0; end
    m_ovr = 0; scramble = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_lane", out_lane, 0);
    chk("rst_is_hi", out_is_hi, 0);
    reset_n = 1;
    @(negedge clk);

    // Single drain with ready held high.
    for (int i = 0; i < NA; i++) begin lo[i] = DW'(18'h100 + i); hi[i] = DW'(18'h200 + i); end
    step(1, 1, 0);
    chk("first_word", out_data, 18'h100);
    for (int j = 0; j < 2*NA; j++) step(0, 1, 0);
    chk("idle_after_drain", busy, 0);

    // Backpressure with snapshot isolation.
    scramble = 1;
    step(1, 0, 0);
    for (int j = 0; j < 40 && q.size() > 0; j++) step(0, 1'($urandom_range(0, 1)), 0);
    while (q.size() > 0) step(0, 1, 0);

    // Capture on the 3rd word drops; capture on last acceptance chains.
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("ovr_set", overrun, 1);
    while (q.size() > 1) step(0, 1, 0);
    step(1, 1, 0);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_ovr_kept", overrun, 1);
    step(1, 0, 1);
    chk("set_wins", overrun, 1);
    step(0, 0, 1);
    chk("ovr_clr", overrun, 0);

    // Reset asserted asynchronously at word 5.
    while (q.size() > 2*NA - 4) step(0, 1, 0);
    #2 reset_n = 0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ovr", overrun, 0);
    q.delete(); m_ovr = 0;
    @(negedge clk);
    reset_n = 1;
    step(1, 1, 0);
    chk("post_rst_lane", out_lane, 0);

    // Long randomized run.
    for (int j = 0; j < 600; j++)
      step(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));

    // Single-lane instance at full-scale values.
    acc_low1 = 18'h3FFFF; acc_hi1 = 18'h3FFFF;
    capture1 = 1;
    @(posedge clk); #1 capture1 = 0;
    @(negedge clk);
    chk("n1_valid0", out_valid1, 1);
    chk("n1_data0", out_data1, 18'h3FFFF);
    chk("n1_lane0", out_lane1, 0);
    chk("n1_hi0", out_is_hi1, 0);
    chk("n1_last0", out_last1, 0);
    out_ready1 = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("n1_valid1", out_valid1, 1);
    chk("n1_data1", out_data1, 18'h3FFFF);
    chk("n1_lane1", out_lane1, 0);
    chk("n1_hi1", out_is_hi1, 1);
    chk("n1_last1", out_last1, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("n1_idle", out_valid1, 0);
    chk("n1_ovr", overrun1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
